frame_config_loader: RTL

//  Upstream feeder of the tile configuration chain. Accepts a 32-bit config word stream (valid/ready),

---
 rtl/frame_config_loader_pkg.sv | 9 +
 rtl/frame_config_loader_if.sv | 9 +
 rtl/frame_config_loader_row_reg.sv | 14 +
 rtl/frame_config_loader.sv | 99 +++++++++
 4 files changed

// File: rtl/frame_config_loader_pkg.sv
// frame_config_loader_pkg: header layout, sync word and FSM encoding shared by the loader files
package frame_config_loader_pkg;
    localparam int CFG_W = 32;
    localparam logic [7:0] SYNC_WORD = 8'hFA;
    localparam int SYNC_LSB = 24;
    localparam int COL_LSB = 19;
    localparam int FRAME_LSB = 14;
    typedef enum logic [1:0] {IDLE, LOAD, STROBE} state_e;
endpackage

// File: rtl/frame_config_loader_if.sv
// frame_config_loader_if: valid/ready config word stream
interface frame_config_loader_if;
    import frame_config_loader_pkg::*;
    logic [CFG_W-1:0] cfg_data;
    logic cfg_valid;
    logic cfg_ready;
    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/frame_config_loader_row_reg.sv
// frame_config_loader_row_reg: one row's FrameData slice, cleared by reset, loaded on enable
module frame_config_loader_row_reg #(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);
    logic [Width-1:0] data_q;
    always_ff @(posedge clk) data_q <= rst ? '0 : en_i ? d_i : data_q;
    assign q_o = data_q;
endmodule

// File: rtl/frame_config_loader.sv
// frame_config_loader: streams config words into per-row FrameData, then pulses one FrameStrobe bit
module frame_config_loader
    import frame_config_loader_pkg::*;
#(
    parameter int         FrameBitsPerRow = 32,
    parameter int         MaxFramesPerCol = 20,
    parameter int         NumRows         = 8,
    parameter logic [4:0] ColId           = 5'd0
) (
    input  logic                               UserCLK,
    input  logic                               reset,
    frame_config_loader_if.slave               cfg,
    output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0]         FrameStrobe,
    output logic                               busy,
    output logic                               err,
    output logic [15:0]                        frames_done
);
    localparam int RowW = NumRows > 1 ? $clog2(NumRows) : 1;
    state_e state_q, state_d;
    logic [RowW-1:0] row_cnt_q, row_cnt_d;
    logic [4:0] col_q, col_d, frame_q, frame_d;
    logic err_q, err_d;
    logic [15:0] frames_done_q, frames_done_d;
    logic accept, hdr_ok, last_row, col_hit, frame_ok, fire, row_we;
    assign accept = cfg.cfg_valid && cfg.cfg_ready;
    assign hdr_ok = cfg.cfg_data[SYNC_LSB +: 8] == SYNC_WORD;
    assign last_row = row_cnt_q == RowW'(NumRows - 1);
    assign col_hit = col_q == ColId;
    assign frame_ok = int'(frame_q) < MaxFramesPerCol;
    assign err = err_q;
    assign frames_done = frames_done_q;
    always_ff @(posedge UserCLK) begin
        if (reset) begin
            state_q       <= IDLE;
            row_cnt_q     <= '0;
            col_q         <= '0;
            frame_q       <= '0;
            err_q         <= 1'b0;
            frames_done_q <= '0;
        end else begin
            state_q       <= state_d;
            row_cnt_q     <= row_cnt_d;
            col_q         <= col_d;
            frame_q       <= frame_d;
            err_q         <= err_d;
            frames_done_q <= frames_done_d;
        end
    end
    always_comb begin
        state_d       = state_q;
        row_cnt_d     = row_cnt_q;
        col_d         = col_q;
        frame_d       = frame_q;
        err_d         = err_q;
        frames_done_d = frames_done_q;
        case (state_q)
            IDLE: begin
                if (accept && hdr_ok) begin
                    state_d   = LOAD;
                    row_cnt_d = '0;
                    col_d     = cfg.cfg_data[COL_LSB +: 5];
                    frame_d   = cfg.cfg_data[FRAME_LSB +: 5];
                end else if (accept) begin
                    err_d = 1'b1;
                end
            end
            LOAD: begin
                if (accept) begin
                    row_cnt_d = last_row ? '0 : row_cnt_q + RowW'(1);
                    state_d   = last_row ? STROBE : LOAD;
                end
            end
            STROBE: begin
                state_d = IDLE;
                // frames for other columns pass silently; only our own bad index is an error
                if (col_hit && frame_ok) frames_done_d = frames_done_q + 16'(frames_done_q != 16'hFFFF);
                if (col_hit && !frame_ok) err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        cfg.cfg_ready = !reset && state_q != STROBE;
        busy          = state_q != IDLE;
        fire          = !reset && state_q == STROBE && col_hit && frame_ok;
        row_we        = state_q == LOAD && accept && col_hit;
        FrameStrobe   = fire ? MaxFramesPerCol'(1) << frame_q : '0;
    end
    for (genvar r = 0; r < NumRows; r++) begin : g_row
        frame_config_loader_row_reg #(.Width(FrameBitsPerRow)) u_row (
            .clk  (UserCLK),
            .rst  (reset),
            .en_i (row_we && row_cnt_q == RowW'(r)),
            .d_i  (cfg.cfg_data[FrameBitsPerRow-1:0]),
            .q_o  (FrameData[r*FrameBitsPerRow +: FrameBitsPerRow])
        );
    end
endmodule
